// File: rtl/updown_dir_if.sv
// Link between the direction controller and the up/down counter it steers.
// master = direction controller, slave = counter.
interface updown_dir_if #(
  parameter int WIDTH = 6
);
  logic [WIDTH-1:0] Count;
  logic             UpOrDown;
  logic             turn;

  modport master (input Count, output UpOrDown, output turn);
  modport slave  (output Count, input UpOrDown, input turn);
endinterface

// File: rtl/updown_dir_ctrl.sv
// Direction controller for the up/down counter: debounced button toggle (MANUAL)
// or LO/HI ping-pong (AUTO). All outputs are registered.
module updown_dir_ctrl #(
  parameter int WIDTH      = 6,
  parameter int LO         = 5,
  parameter int HI         = 40,
  parameter int DEB_CYCLES = 4
) (
  input  logic          Clk,
  input  logic          reset,
  input  logic          mode,
  input  logic          btn_raw,
  updown_dir_if.master  bus
);
  localparam int CW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0]    DEB_LAST = CW'(DEB_CYCLES - 1);
  localparam logic [WIDTH-1:0] HI_M1    = WIDTH'(HI - 1);
  localparam logic [WIDTH-1:0] LO_P1    = WIDTH'(LO + 1);

  typedef enum logic {DN = 1'b0, UP = 1'b1} dir_t;

  logic          s1, s2, deb, turn_q, press;
  logic [CW-1:0] cnt;
  dir_t          dir, dir_nxt;

  // deb rises on exactly this edge; releases never qualify
  assign press = s2 & ~deb & (cnt == DEB_LAST);

  // one-step lookahead because the counter sees the direction a cycle late
  always_comb begin
    dir_nxt = dir;
    if (mode) begin
      if (dir == UP && bus.Count >= HI_M1)      dir_nxt = DN;
      else if (dir == DN && bus.Count <= LO_P1) dir_nxt = UP;
    end else if (press) begin
      dir_nxt = (dir == UP) ? DN : UP;
    end
  end

  always_ff @(posedge Clk) begin
    if (reset) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      deb    <= 1'b0;
      cnt    <= '0;
      dir    <= UP;
      turn_q <= 1'b0;
    end else begin
      s1 <= btn_raw;
      s2 <= s1;
      if (s2 == deb) begin
        cnt <= '0;
      end else if (cnt == DEB_LAST) begin
        deb <= s2;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
      dir    <= dir_nxt;
      turn_q <= (dir_nxt != dir);
    end
  end

  assign bus.UpOrDown = dir;
  assign bus.turn     = turn_q;
endmodule

// File: tb/tb_updown_dir_ctrl.sv
// Bench for updown_dir_ctrl: closed loop with a counter model, directed scenarios
// and a randomized phase checked against a behavioural reference each cycle.
module tb_updown_dir_ctrl;
  localparam int WIDTH = 6, LO = 5, HI = 40, DEB = 4;

  logic Clk = 1'b0, reset = 1'b1, mode = 1'b0, btn_raw = 1'b0;
  logic [WIDTH-1:0] Count_v = '0;
  bit cnt_run = 0;

  updown_dir_if #(.WIDTH(WIDTH)) cif();
  assign cif.Count = Count_v;

  updown_dir_ctrl #(.WIDTH(WIDTH), .LO(LO), .HI(HI), .DEB_CYCLES(DEB)) dut (
    .Clk(Clk), .reset(reset), .mode(mode), .btn_raw(btn_raw), .bus(cif)
  );

  always #5 Clk = ~Clk;

  int n_chk = 0, n_err = 0;

  // reference: last two raw samples, debounced level, length of current disagreement run
  bit m_dir = 1, m_turn = 0, h1 = 0, h2 = 0, m_deb = 0;
  int m_run = 0;

  // observation of DUT direction changes
  logic prev_ud = 1'b0;
  int idx = 0, tog = 0, last_tog = -1;

  // window tracking for AUTO ping-pong
  bit trk = 0, seen = 0;
  int mn = 0, mx = 0, bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    bit pre_dir, nd, press;
    pre_dir = m_dir;
    if (reset) begin
      m_dir = 1; m_turn = 0; h1 = 0; h2 = 0; m_deb = 0; m_run = 0;
    end else begin
      press = 0;
      if (h2 != m_deb) begin
        m_run++;
        if (m_run == DEB) begin
          m_deb = h2; m_run = 0; press = h2;
        end
      end else begin
        m_run = 0;
      end
      h2 = h1; h1 = btn_raw;
      nd = m_dir;
      if (mode) begin
        if (m_dir && int'(Count_v) + 1 >= HI)       nd = 0;
        else if (!m_dir && int'(Count_v) - 1 <= LO) nd = 1;
      end else if (press) begin
        nd = !m_dir;
      end
      m_turn = (nd != m_dir);
      m_dir  = nd;
    end
    @(posedge Clk); #1;
    if (cnt_run) Count_v = pre_dir ? Count_v + 1'b1 : Count_v - 1'b1;
    chk("UpOrDown", 32'(cif.UpOrDown), 32'(m_dir));
    chk("turn", 32'(cif.turn), 32'(m_turn));
    if (cif.UpOrDown !== prev_ud) begin
      tog++;
      last_tog = idx;
    end
    prev_ud = cif.UpOrDown;
    idx++;
    if (trk) begin
      if (int'(Count_v) == HI) seen = 1;
      if (seen) begin
        if (int'(Count_v) < mn) mn = int'(Count_v);
        if (int'(Count_v) > mx) mx = int'(Count_v);
        if (cif.turn && int'(Count_v) != HI && int'(Count_v) != LO) bad++;
      end
    end
  endtask

  task automatic start_trk();
    trk = 1; seen = 0; mn = 1 << WIDTH; mx = -1; bad = 0;
  endtask

  initial begin
    int hold;
    bit found;

    // reset and idle hold
    reset = 1; mode = 0; btn_raw = 0; cnt_run = 0;
    repeat (3) begin
      step();
      chk("rst_dir", 32'(cif.UpOrDown), 32'd1);
      chk("rst_turn", 32'(cif.turn), 32'd0);
    end
    reset = 0;
    repeat (50) begin
      step();
      chk("idle_dir", 32'(cif.UpOrDown), 32'd1);
    end

    // AUTO ping-pong from Count=0
    reset = 1; step(); reset = 0;
    Count_v = '0; mode = 1; cnt_run = 1;
    start_trk();
    repeat (250) step();
    trk = 0;
    chk("auto_max", 32'(mx), 32'(HI));
    chk("auto_min", 32'(mn), 32'(LO));
    chk("auto_turn_pos", 32'(bad), 32'd0);

    // debounce: short pulse, long press, release
    reset = 1; mode = 0; cnt_run = 0; step(); reset = 0;
    repeat (5) step();
    idx = 0; tog = 0;
    btn_raw = 1; repeat (3) step();
    btn_raw = 0; repeat (15) step();
    chk("short_pulse_tog", 32'(tog), 32'd0);
    idx = 0; tog = 0;
    btn_raw = 1; repeat (12) step();
    chk("press_tog", 32'(tog), 32'd1);
    chk("press_edge", 32'(last_tog), 32'(DEB + 1));
    btn_raw = 0; repeat (15) step();
    chk("release_tog", 32'(tog), 32'd1);

    // bounce then hold
    idx = 0; tog = 0;
    for (int i = 0; i < 8; i++) begin
      btn_raw = (i % 2 == 0);
      step();
    end
    btn_raw = 1; repeat (20) step();
    chk("bounce_tog", 32'(tog), 32'd1);
    chk("bounce_edge", 32'(last_tog), 32'(8 + DEB + 1));
    btn_raw = 0; repeat (15) step();

    // out-of-window entry into AUTO at Count=50 while counting up
    Count_v = 6'd44; cnt_run = 1;
    repeat (6) step();
    mode = 1;
    step();
    chk("oow_dir", 32'(cif.UpOrDown), 32'd0);
    chk("oow_turn", 32'(cif.turn), 32'd1);
    start_trk();
    repeat (250) step();
    trk = 0;
    chk("oow_max", 32'(mx), 32'(HI));
    chk("oow_min", 32'(mn), 32'(LO));
    chk("oow_turn_pos", 32'(bad), 32'd0);

    // reset while descending at Count=20 with button held
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      step();
      if (int'(Count_v) == 20 && !m_dir) found = 1;
    end
    chk("find_desc20", 32'(found), 32'd1);
    btn_raw = 1; reset = 1;
    step();
    chk("midrst_dir", 32'(cif.UpOrDown), 32'd1);
    chk("midrst_turn", 32'(cif.turn), 32'd0);
    reset = 0; mode = 0;
    idx = 0; tog = 0;
    repeat (12) step();
    chk("midrst_tog", 32'(tog), 32'd1);
    chk("midrst_edge", 32'(last_tog), 32'(DEB + 1));
    btn_raw = 0;

    // randomized: bouncy button, mode flips, occasional reset
    hold = 0;
    for (int i = 0; i < 600; i++) begin
      if (hold == 0) begin
        btn_raw = 1'($urandom_range(0, 1));
        hold = $urandom_range(1, 7);
      end
      hold--;
      if ($urandom_range(0, 49) == 0) mode = !mode;
      reset = ($urandom_range(0, 99) == 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/updown_dir_ctrl.md
# updown_dir_ctrl

Direction controller that drives the `UpOrDown` input of the 6-bit up/down counter. It watches the counter's `Count` output and operates in one of two modes:
- MANUAL: a debounced push-button toggles the count direction on each press.
- AUTO: the counter ping-pongs between a programmable low limit and high limit.

It sits directly upstream of the counter, on the same clock, and feeds it a registered direction bit.

## Interface
Parameters:
- WIDTH, 6 — width of the `Count` input; matches the counter.
- LO, 5 — AUTO-mode low turnaround value.
- HI, 40 — AUTO-mode high turnaround value. Legal range: LO+2 ≤ HI ≤ 2^WIDTH−1.
- DEB_CYCLES, 4 — number of consecutive stable synchronized samples needed to accept a button level change. Must be ≥ 2.

Ports:
- Clk  in  1  — single clock; all state updates on the rising edge.
- reset  in  1  — synchronous, active-high reset.
- mode  in  1  — 0 = MANUAL, 1 = AUTO. Synchronous to Clk; sampled every edge.
- btn_raw  in  1  — asynchronous, bouncy push-button, active-high.
- Count  in  WIDTH  — current counter value, fed back from the counter.
- UpOrDown  out  1  — registered direction bit to the counter: 1 = count up, 0 = count down.
- turn  out  1  — registered one-cycle pulse; high in each cycle where `UpOrDown` holds a value different from the previous cycle.

## Operation
- Reset (reset=1 sampled at an edge):
  - UpOrDown=1, turn=0.
  - Synchronizer flops s1 and s2 = 0.
  - Debounced level deb = 0; stability counter = 0.
  - Reset has priority over every other event.
- Synchronizer: s1 ← btn_raw, s2 ← s1.
- Debouncer:
  - If s2 == deb: counter ← 0.
  - Otherwise: counter increments.
  - On the edge where s2 ≠ deb and counter == DEB_CYCLES−1: deb ← s2 and counter ← 0.
  - The debouncer runs in both modes.
- Press event: the edge at which deb changes 0 → 1. A release (1 → 0) never produces an event.
- MANUAL (mode=0):
  - A press event toggles UpOrDown at that same edge.
  - Count is ignored.
- AUTO (mode=1):
  - Press events are ignored.
  - If UpOrDown=1 and Count ≥ HI−1: UpOrDown ← 0 at the next edge.
  - If UpOrDown=0 and Count ≤ LO+1: UpOrDown ← 1 at the next edge.
  - Otherwise UpOrDown holds.
  - The lookahead of one step compensates for the registered output. Steady-state sequence: …, HI−1, HI, HI−1, …, LO+1, LO, LO+1, …
  - Out-of-window entry: Count > HI while up, or Count < LO while down, reverses the direction at the first AUTO edge. Count < LO while up, or Count > HI while down, simply holds and converges into the window.
- Mode switching:
  - mode takes effect at the edge where it is sampled.
  - A press event coinciding with the first AUTO edge is dropped.
  - Switching AUTO → MANUAL keeps the current UpOrDown.
- turn: at every edge, turn ← (next UpOrDown ≠ current UpOrDown).

## Timing
- All outputs are registered. There is no combinational path from any input to any output.
- Manual press latency: take edge 0 as the first edge that samples btn_raw=1.
  - s2=1 at edge 1.
  - deb rises and UpOrDown toggles at edge DEB_CYCLES+1 (edge 5 for the default).
  - turn=1 for the cycle following that edge.
- Pulse filtering:
  - An s2 high run shorter than DEB_CYCLES edges is discarded.
  - Any bounce resets the stability counter.
- AUTO turnaround: UpOrDown changes at the same edge where the counter reaches HI (or LO). The counter therefore reverses on the following edge. The counter's value never exceeds HI or goes below LO once inside the window.
- Reset mid-operation:
  - Outputs take their reset values at the reset edge.
  - A button held through reset must be re-qualified. In MANUAL, the toggle occurs DEB_CYCLES+1 edges after the first non-reset edge.

## Test plan
1. Reset: hold reset=1 for 3 cycles with btn_raw=0 and mode=0 → UpOrDown=1 and turn=0 during and after reset. UpOrDown stays 1 for 50 cycles.
2. AUTO ping-pong: counter model in loop, Count=0 after reset, mode=1 → Count rises to 40, falls to 5, rises to 40.
   - UpOrDown falls at the edge where Count becomes 40, and rises at the edge where Count becomes 5.
   - turn is high exactly in those 2 cycles per period.
3. Debounce: MANUAL, btn_raw high for 3 cycles → no toggle. btn_raw high for 12 cycles → exactly one toggle, at edge 5 after the first sample. Release → no toggle.
4. Bounce: MANUAL, btn_raw alternates 1/0 for 8 cycles then stays 1 → exactly one toggle, DEB_CYCLES+1 edges after the last rising transition.
5. Out-of-window: MANUAL, count up to Count=50, then set mode=1 → at the next edge UpOrDown=0 and turn=1. Count descends and then ping-pongs between 5 and 40.
6. Reset mid-operation: AUTO descending at Count=20, assert reset for 1 cycle while btn_raw is held at 1, then mode=0 → UpOrDown=1 at the reset edge and turn=0. A single toggle occurs DEB_CYCLES+1 edges after reset deasserts.
